// File: rtl/jenc_frame_ctrl_if.sv
// Encoder-side bundle: latched config and flush toward the encoder,
// plus the monitored output beat (valid/hold/tlast) and running byte count.
interface jenc_frame_ctrl_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic          enc_out_valid;
  logic          enc_out_hold;
  logic          enc_out_tlast;
  logic [19:0]   enc_size;
  logic [1:0]    enc_qf_select;
  logic [XW-1:0] enc_x_size_m1;
  logic [YW-1:0] enc_y_size_m1;
  logic          enc_flush;

  modport master (
    input  enc_out_valid,
    input  enc_out_hold,
    input  enc_out_tlast,
    input  enc_size,
    output enc_qf_select,
    output enc_x_size_m1,
    output enc_y_size_m1,
    output enc_flush
  );

  modport slave (
    output enc_out_valid,
    output enc_out_hold,
    output enc_out_tlast,
    output enc_size,
    input  enc_qf_select,
    input  enc_x_size_m1,
    input  enc_y_size_m1,
    input  enc_flush
  );
endinterface

// File: rtl/jenc_frame_ctrl.sv
// JPEG encoder frame controller: start/abort, sof/eof gating, tlast drain.
// Ports: clk, reset, start, abort, cfg in, sof, eof, enc (if), status out.
module jenc_frame_ctrl #(
  parameter int SENSOR_X_SIZE  = 1280,
  parameter int SENSOR_Y_SIZE  = 720,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [1:0]                       qf_select_in,
  input  logic [$clog2(SENSOR_X_SIZE)-1:0] x_size_m1_in,
  input  logic [$clog2(SENSOR_Y_SIZE)-1:0] y_size_m1_in,
  input  logic                             sof,
  input  logic                             eof,
  jenc_frame_ctrl_if.master                enc,
  output logic                             gate_en,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [19:0]                      frame_size,
  output logic [7:0]                       frame_count
);
  localparam int XW = $clog2(SENSOR_X_SIZE);
  localparam int YW = $clog2(SENSOR_Y_SIZE);
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_ARMED,
    S_ENCODE,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          flush_idx;
  logic          flush_idx_nxt;
  logic          flush_to_idle;
  logic          flush_to_idle_nxt;
  logic [TW-1:0] idle_cnt;
  logic [TW-1:0] idle_cnt_nxt;
  logic          beat;
  logic          tlast_beat;
  logic          accept_start;
  logic          frame_ok;

  assign beat       = enc.enc_out_valid & ~enc.enc_out_hold;
  assign tlast_beat = beat & enc.enc_out_tlast;

  assign accept_start = start &
    ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));

  always_comb begin
    state_nxt         = state;
    flush_idx_nxt     = 1'b0;
    flush_to_idle_nxt = flush_to_idle;
    idle_cnt_nxt      = '0;
    frame_ok          = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_nxt         = S_FLUSH;
          flush_to_idle_nxt = 1'b0;
        end
      end
      S_FLUSH: begin
        // Two flush cycles: index 0 then 1.
        flush_idx_nxt = 1'b1;
        if (flush_idx)
          state_nxt = flush_to_idle ? S_IDLE : S_ARMED;
      end
      S_ARMED: begin
        if (abort) begin
          state_nxt         = S_FLUSH;
          flush_to_idle_nxt = 1'b1;
        end else if (sof) begin
          state_nxt = S_ENCODE;
        end
      end
      S_ENCODE: begin
        if (abort) begin
          state_nxt         = S_FLUSH;
          flush_to_idle_nxt = 1'b1;
        end else if (sof | tlast_beat) begin
          state_nxt = S_ERROR;
        end else if (eof) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_nxt         = S_FLUSH;
          flush_to_idle_nxt = 1'b1;
        end else if (sof) begin
          state_nxt = S_ERROR;
        end else if (tlast_beat) begin
          state_nxt = S_DONE;
          frame_ok  = 1'b1;
        end else if (beat) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = S_ERROR;
        end else begin
          idle_cnt_nxt = idle_cnt + TW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they
  // line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      flush_idx         <= 1'b0;
      flush_to_idle     <= 1'b0;
      idle_cnt          <= '0;
      gate_en           <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      frame_size        <= '0;
      frame_count       <= '0;
      enc.enc_flush     <= 1'b0;
      enc.enc_qf_select <= '0;
      enc.enc_x_size_m1 <= XW'(SENSOR_X_SIZE - 1);
      enc.enc_y_size_m1 <= YW'(SENSOR_Y_SIZE - 1);
    end else begin
      state         <= state_nxt;
      flush_idx     <= flush_idx_nxt;
      flush_to_idle <= flush_to_idle_nxt;
      idle_cnt      <= idle_cnt_nxt;
      gate_en       <= (state_nxt == S_ENCODE);
      enc.enc_flush <= (state_nxt == S_FLUSH);
      busy          <= state_nxt inside
        {S_FLUSH, S_ARMED, S_ENCODE, S_DRAIN};
      done          <= (state_nxt == S_DONE);
      error         <= (state_nxt == S_ERROR);
      if (accept_start) begin
        enc.enc_qf_select <= qf_select_in;
        enc.enc_x_size_m1 <= x_size_m1_in;
        enc.enc_y_size_m1 <= y_size_m1_in;
      end
      if (frame_ok) begin
        frame_size  <= enc.enc_size;
        frame_count <= frame_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_jenc_frame_ctrl.sv
// Self-checking bench for jenc_frame_ctrl with randomized frames
// and a small behavioural model of size/count/config.
module tb_jenc_frame_ctrl;
  localparam int XS = 1280;
  localparam int YS = 720;
  localparam int TO = 16;
  localparam int XW = $clog2(XS);
  localparam int YW = $clog2(YS);

  // {busy, done, error, gate_en, enc_flush} per phase
  localparam logic [4:0] P_IDLE   = 5'b00000;
  localparam logic [4:0] P_FLUSH  = 5'b10001;
  localparam logic [4:0] P_ARMED  = 5'b10000;
  localparam logic [4:0] P_ENCODE = 5'b10010;
  localparam logic [4:0] P_DRAIN  = 5'b10000;
  localparam logic [4:0] P_DONE   = 5'b01000;
  localparam logic [4:0] P_ERROR  = 5'b00100;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          sof;
  logic          eof;
  logic [1:0]    qf_select_in;
  logic [XW-1:0] x_size_m1_in;
  logic [YW-1:0] y_size_m1_in;
  logic          gate_en;
  logic          busy;
  logic          done;
  logic          error;
  logic [19:0]   frame_size;
  logic [7:0]    frame_count;

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [7:0]    m_count;
  logic [19:0]   m_size;
  logic [1:0]    m_qf;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;

  jenc_frame_ctrl_if #(.XW(XW), .YW(YW)) enc ();

  jenc_frame_ctrl #(
    .SENSOR_X_SIZE (XS),
    .SENSOR_Y_SIZE (YS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .qf_select_in(qf_select_in),
    .x_size_m1_in(x_size_m1_in),
    .y_size_m1_in(y_size_m1_in),
    .sof         (sof),
    .eof         (eof),
    .enc         (enc),
    .gate_en     (gate_en),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .frame_size  (frame_size),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] st();
    return {busy, done, error, gate_en, enc.enc_flush};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; abort = 0; sof = 0; eof = 0;
    enc.enc_out_valid = 0;
    enc.enc_out_hold  = 0;
    enc.enc_out_tlast = 0;
  endtask

  task automatic set_beat(input logic v, input logic h,
                          input logic t, input logic [19:0] s);
    enc.enc_out_valid = v;
    enc.enc_out_hold  = h;
    enc.enc_out_tlast = t;
    enc.enc_size      = s;
  endtask

  // Accepted start, then two flush cycles: leaves DUT in ARMED.
  task automatic go_start(input logic [1:0] q,
                          input logic [XW-1:0] x,
                          input logic [YW-1:0] y);
    qf_select_in = q; x_size_m1_in = x; y_size_m1_in = y;
    start = 1; tick(); start = 0;
    m_qf = q; m_x = x; m_y = y;
    tick(); tick();
  endtask

  task automatic test_reset();
    idle_in();
    enc.enc_size = '0;
    qf_select_in = 0; x_size_m1_in = 0; y_size_m1_in = 0;
    reset = 1; tick(); tick(); reset = 0;
    m_count = 0; m_size = 0; m_qf = 0;
    m_x = XW'(XS - 1); m_y = YW'(YS - 1);
    checks++;
    if (st() !== P_IDLE) begin
      failures++;
      $display("FAIL reset_status got=%b exp=%b", st(), P_IDLE);
    end
    checks++;
    if (frame_size !== m_size || frame_count !== m_count) begin
      failures++;
      $display("FAIL reset_frame got=%h/%0d exp=0/0",
               frame_size, frame_count);
    end
    checks++;
    if (enc.enc_qf_select !== m_qf || enc.enc_x_size_m1 !== m_x ||
        enc.enc_y_size_m1 !== m_y) begin
      failures++;
      $display("FAIL reset_cfg got=%0d/%0d/%0d exp=%0d/%0d/%0d",
               enc.enc_qf_select, enc.enc_x_size_m1,
               enc.enc_y_size_m1, m_qf, m_x, m_y);
    end
    tick();
  endtask

  task automatic test_basic_frame();
    int fc;
    qf_select_in = 2; x_size_m1_in = 1279; y_size_m1_in = 719;
    start = 1; tick(); start = 0;
    m_qf = 2; m_x = 1279; m_y = 719;
    checks++;
    if (st() !== P_FLUSH || enc.enc_qf_select !== 2'd2 ||
        enc.enc_x_size_m1 !== 11'd1279 ||
        enc.enc_y_size_m1 !== 10'd719) begin
      failures++;
      $display("FAIL basic_start st=%b qf=%0d x=%0d y=%0d exp st=%b 2/1279/719",
               st(), enc.enc_qf_select, enc.enc_x_size_m1,
               enc.enc_y_size_m1, P_FLUSH);
    end
    fc = 0;
    for (int i = 0; i < 8 && enc.enc_flush; i++) begin
      fc++; tick();
    end
    checks++;
    if (fc != 2 || st() !== P_ARMED) begin
      failures++;
      $display("FAIL basic_flush cycles=%0d st=%b exp=2 %b",
               fc, st(), P_ARMED);
    end
    eof = 1; tick(); eof = 0;
    checks++;
    if (st() !== P_ARMED) begin
      failures++;
      $display("FAIL basic_eof_armed got=%b exp=%b", st(), P_ARMED);
    end
    sof = 1; tick(); sof = 0;
    checks++;
    if (st() !== P_ENCODE) begin
      failures++;
      $display("FAIL basic_sof got=%b exp=%b", st(), P_ENCODE);
    end
    for (int i = 0; i < 3; i++) begin
      set_beat(1'b1, 1'($urandom), 1'b0, 20'($urandom));
      tick();
      checks++;
      if (st() !== P_ENCODE) begin
        failures++;
        $display("FAIL basic_encode got=%b exp=%b", st(), P_ENCODE);
      end
    end
    set_beat(0, 0, 0, 0);
    eof = 1; tick(); eof = 0;
    checks++;
    if (st() !== P_DRAIN) begin
      failures++;
      $display("FAIL basic_eof got=%b exp=%b", st(), P_DRAIN);
    end
    set_beat(1, 0, 1, 20'h1A2B3); tick(); set_beat(0, 0, 0, 0);
    m_count = m_count + 1; m_size = 20'h1A2B3;
    checks++;
    if (st() !== P_DONE || frame_size !== 20'h1A2B3 ||
        frame_count !== 8'd1) begin
      failures++;
      $display("FAIL basic_done st=%b size=%h cnt=%0d exp=%b 1a2b3 1",
               st(), frame_size, frame_count, P_DONE);
    end
  endtask

  task automatic test_start_ignored();
    go_start(2, 11'($urandom_range(0, XS - 1)),
             10'($urandom_range(0, YS - 1)));
    sof = 1; tick(); sof = 0;
    qf_select_in = 3; x_size_m1_in = ~m_x; y_size_m1_in = ~m_y;
    start = 1; tick(); start = 0;
    checks++;
    if (st() !== P_ENCODE || enc.enc_qf_select !== 2'd2 ||
        enc.enc_x_size_m1 !== m_x || enc.enc_y_size_m1 !== m_y) begin
      failures++;
      $display("FAIL start_ignored st=%b qf=%0d x=%0d exp=%b 2 %0d",
               st(), enc.enc_qf_select, enc.enc_x_size_m1,
               P_ENCODE, m_x);
    end
    eof = 1; tick(); eof = 0;
    set_beat(1, 0, 1, 20'h00777); tick(); set_beat(0, 0, 0, 0);
    m_count = m_count + 1; m_size = 20'h00777;
    checks++;
    if (st() !== P_DONE || frame_count !== m_count ||
        frame_size !== m_size) begin
      failures++;
      $display("FAIL start_ignored_done st=%b cnt=%0d exp=%b %0d",
               st(), frame_count, P_DONE, m_count);
    end
  endtask

  // Abort from ARMED, ENCODE and DRAIN, each with competing inputs.
  task automatic test_abort();
    int fc;
    for (int w = 0; w < 3; w++) begin
      go_start(2'($urandom), 11'($urandom_range(0, XS - 1)),
               10'($urandom_range(0, YS - 1)));
      if (w >= 1) begin sof = 1; tick(); sof = 0; end
      if (w == 2) begin eof = 1; tick(); eof = 0; end
      abort = 1; sof = 1; eof = 1; start = 1;
      set_beat(1, 0, 1, 20'hFFFFF);
      tick();
      idle_in();
      fc = 0;
      for (int i = 0; i < 8 && enc.enc_flush; i++) begin
        fc++; tick();
      end
      checks++;
      if (fc != 2 || st() !== P_IDLE || frame_count !== m_count ||
          frame_size !== m_size) begin
        failures++;
        $display("FAIL abort_w%0d flush=%0d st=%b cnt=%0d exp=2 %b %0d",
                 w, fc, st(), frame_count, P_IDLE, m_count);
      end
    end
  endtask

  task automatic test_timeout();
    int b;
    int last;
    logic exp_err;
    for (int trial = 0; trial < 3; trial++) begin
      b = (trial == 0) ? 10 :
          (trial == 1) ? 0 : int'($urandom_range(1, 15));
      go_start(2'($urandom), 11'($urandom), 10'($urandom));
      sof = 1; tick(); sof = 0;
      eof = 1; tick(); eof = 0;
      last = 0;
      exp_err = 0;
      for (int k = 1; k <= 40 && !exp_err; k++) begin
        if (k == b) set_beat(1, 0, 0, 20'($urandom));
        else set_beat(1'($urandom), 1, 1'($urandom), 20'($urandom));
        tick();
        if (k == b) last = k;
        exp_err = (k >= last + TO);
        checks++;
        if (st() !== (exp_err ? P_ERROR : P_DRAIN)) begin
          failures++;
          $display("FAIL timeout_t%0d_k%0d got=%b exp=%b", trial, k,
                   st(), exp_err ? P_ERROR : P_DRAIN);
        end
      end
      set_beat(0, 0, 0, 0);
      checks++;
      if (frame_count !== m_count || frame_size !== m_size) begin
        failures++;
        $display("FAIL timeout_frame cnt=%0d exp=%0d", frame_count,
                 m_count);
      end
    end
  endtask

  task automatic test_encode_errors();
    for (int c = 0; c < 3; c++) begin
      go_start(2'($urandom), 11'($urandom), 10'($urandom));
      sof = 1; tick(); sof = 0;
      if (c == 0) set_beat(1, 0, 1, 20'h12345);
      if (c == 1) sof = 1;
      if (c == 2) begin eof = 1; tick(); eof = 0; sof = 1; end
      tick();
      idle_in();
      checks++;
      if (st() !== P_ERROR || frame_count !== m_count ||
          frame_size !== m_size) begin
        failures++;
        $display("FAIL err_case%0d st=%b cnt=%0d exp=%b %0d",
                 c, st(), frame_count, P_ERROR, m_count);
      end
    end
  endtask

  task automatic test_sof_eof_same();
    go_start(1, 11'd639, 10'd479);
    sof = 1; eof = 1; tick(); sof = 0; eof = 0;
    tick();
    checks++;
    if (st() !== P_ENCODE) begin
      failures++;
      $display("FAIL sof_eof_same got=%b exp=%b", st(), P_ENCODE);
    end
    eof = 1; tick(); eof = 0;
    set_beat(1, 0, 1, 20'h0BEEF); tick(); set_beat(0, 0, 0, 0);
    m_count = m_count + 1; m_size = 20'h0BEEF;
    checks++;
    if (st() !== P_DONE || frame_size !== m_size) begin
      failures++;
      $display("FAIL sof_eof_same_done st=%b size=%h exp=%b %h",
               st(), frame_size, P_DONE, m_size);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]    q;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [19:0]   s;
    int            n;
    int            gcnt;
    for (int f = 0; f < 20; f++) begin
      q = 2'($urandom);
      x = 11'($urandom_range(0, XS - 1));
      y = 10'($urandom_range(0, YS - 1));
      qf_select_in = q; x_size_m1_in = x; y_size_m1_in = y;
      start = 1; tick(); start = 0;
      m_qf = q; m_x = x; m_y = y;
      checks++;
      if (st() !== P_FLUSH || enc.enc_qf_select !== m_qf ||
          enc.enc_x_size_m1 !== m_x || enc.enc_y_size_m1 !== m_y) begin
        failures++;
        $display("FAIL b2b_cfg f%0d st=%b qf=%0d x=%0d y=%0d exp=%b %0d %0d %0d",
                 f, st(), enc.enc_qf_select, enc.enc_x_size_m1,
                 enc.enc_y_size_m1, P_FLUSH, m_qf, m_x, m_y);
      end
      tick(); tick();
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        eof = 1'($urandom); tick(); eof = 0;
      end
      sof = 1; tick(); sof = 0;
      n = $urandom_range(1, 8);
      gcnt = 0;
      for (int i = 0; i < n; i++) begin
        if (gate_en) gcnt++;
        set_beat(1'($urandom), 1'($urandom), 1'b0, 20'($urandom));
        if (enc.enc_out_hold) enc.enc_out_tlast = 1'($urandom);
        tick();
      end
      if (gate_en) gcnt++;
      set_beat(0, 0, 0, 0);
      eof = 1; tick(); eof = 0;
      checks++;
      if (gcnt != n + 1 || st() !== P_DRAIN) begin
        failures++;
        $display("FAIL b2b_gate f%0d gate=%0d st=%b exp=%0d %b",
                 f, gcnt, st(), n + 1, P_DRAIN);
      end
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
        set_beat(1'($urandom), 1'($urandom), 1'b0, 20'($urandom));
        if (enc.enc_out_hold) enc.enc_out_tlast = 1'($urandom);
        tick();
      end
      s = 20'($urandom);
      set_beat(1, 0, 1, s); tick(); set_beat(0, 0, 0, 0);
      m_count = m_count + 1; m_size = s;
      checks++;
      if (st() !== P_DONE || frame_size !== m_size ||
          frame_count !== m_count) begin
        failures++;
        $display("FAIL b2b_done f%0d st=%b size=%h cnt=%0d exp=%b %h %0d",
                 f, st(), frame_size, frame_count, P_DONE, m_size,
                 m_count);
      end
    end
  endtask

  task automatic test_wrap();
    logic [19:0] s;
    while (m_count != 8'd255) begin
      go_start(2'($urandom), 11'($urandom), 10'($urandom));
      sof = 1; tick(); sof = 0;
      eof = 1; tick(); eof = 0;
      s = 20'($urandom);
      set_beat(1, 0, 1, s); tick(); set_beat(0, 0, 0, 0);
      m_count = m_count + 1; m_size = s;
    end
    checks++;
    if (frame_count !== 8'd255) begin
      failures++;
      $display("FAIL wrap_255 got=%0d exp=255", frame_count);
    end
    go_start(0, 11'd100, 10'd50);
    sof = 1; tick(); sof = 0;
    eof = 1; tick(); eof = 0;
    set_beat(1, 1, 1, 20'h00ABC); tick();
    checks++;
    if (st() !== P_DRAIN || frame_count !== 8'd255) begin
      failures++;
      $display("FAIL wrap_hold st=%b cnt=%0d exp=%b 255",
               st(), frame_count, P_DRAIN);
    end
    set_beat(1, 0, 1, 20'h00ABC); tick(); set_beat(0, 0, 0, 0);
    m_count = m_count + 1; m_size = 20'h00ABC;
    checks++;
    if (st() !== P_DONE || frame_count !== 8'd0 ||
        frame_size !== m_size) begin
      failures++;
      $display("FAIL wrap_zero st=%b cnt=%0d exp=%b 0",
               st(), frame_count, P_DONE);
    end
  endtask

  task automatic test_reset_mid();
    go_start(1, 11'd200, 10'd100);
    sof = 1; tick(); sof = 0;
    reset = 1; start = 1; abort = 1; sof = 1; eof = 1;
    set_beat(1, 0, 1, 20'h55555);
    tick();
    idle_in();
    reset = 0;
    m_count = 0; m_size = 0; m_qf = 0;
    m_x = XW'(XS - 1); m_y = YW'(YS - 1);
    checks++;
    if (st() !== P_IDLE || frame_count !== m_count ||
        frame_size !== m_size || enc.enc_qf_select !== m_qf ||
        enc.enc_x_size_m1 !== m_x || enc.enc_y_size_m1 !== m_y) begin
      failures++;
      $display("FAIL reset_mid st=%b cnt=%0d qf=%0d x=%0d y=%0d exp=%b 0 0 %0d %0d",
               st(), frame_count, enc.enc_qf_select,
               enc.enc_x_size_m1, enc.enc_y_size_m1, P_IDLE, m_x, m_y);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_start_ignored();
    test_abort();
    test_timeout();
    test_encode_errors();
    test_sof_eof_same();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
